apb_timer_slave: RTL and testbench
==================================

Name: apb_timer_slave

Overview:
- Zero-wait-state APB slave that sits directly downstream of the AHB-to-APB bridge and consumes its PSEL/PENABLE/PADDR/PWRITE/PWDATA; returns PRDATA, which the bridge forwards as HRDATA.
- Provides a programmable down-counting timer with an 8-bit prescaler, one-shot or auto-reload mode, and a level interrupt.
- Runs on the bridge clock and reset. There is no PREADY or PSLVERR, so every access completes in setup + one access cycle.

Parameters:
- ADDR_WIDTH, 32, APB address width; only PADDR[3:2] is decoded.
- DATA_WIDTH, 32, APB data width.
- CNT_WIDTH, 32, counter/LOAD width; must be ≤ DATA_WIDTH.
- PRESC_WIDTH, 8, prescaler width; must be ≤ 8.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset.
- PSEL  in  1  slave select from bridge.
- PENABLE  in  1  access phase.
- PADDR  in  ADDR_WIDTH  byte address.
- PWRITE  in  1  1 = write.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data, registered.
- IRQ  out  1  level interrupt = pending & IRQ_EN.

Behaviour:
- Clock and reset (already decided): reset HRESETn, asynchronous, active-low; clock HCLK.
- Reset values: all registers 0, PRDATA = 0, IRQ = 0. Asserting reset mid-access aborts the access; no partial register update occurs.
- Register map (PADDR[3:2]; upper address bits and PADDR[1:0] are ignored):
  - 0x0 CTRL, RW: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN, [15:8] PRESCALE. Other bits read 0.
  - 0x4 LOAD, RW: reload value [CNT_WIDTH-1:0].
  - 0x8 COUNT, RO: current count. Writes are ignored.
  - 0xC STATUS: [0] PEND. Write 1 clears it; write 0 has no effect. Other bits read 0.
- Write commit: on the HCLK edge where PSEL & PENABLE & PWRITE. Exactly one commit per access.
- Read capture: on the HCLK edge where PSEL & !PENABLE & !PWRITE (setup phase), PRDATA <= selected register. PRDATA is therefore valid throughout the access phase and holds until the next read setup. Writes never change PRDATA.
- Prescaler:
  - psc_cnt counts 0..PRESCALE while EN = 1.
  - tick = EN & (psc_cnt == PRESCALE); psc_cnt wraps to 0 on tick.
  - PRESCALE = 0 gives a tick every cycle.
  - A write to CTRL clears psc_cnt.
  - EN = 0 freezes psc_cnt at 0 and holds COUNT.
- Counter, on tick:
  - COUNT != 0: COUNT <= COUNT - 1.
  - COUNT == 0: expiry. PEND <= 1. If AUTO_RELOAD, COUNT <= LOAD. Otherwise COUNT stays 0 and EN <= 0 (one-shot stop).
  - Period in auto-reload mode = (LOAD+1)*(PRESCALE+1) cycles.
- Write to LOAD: updates LOAD and COUNT in the same edge. This overrides any tick decrement in that cycle.
- Simultaneous events:
  - STATUS W1C and expiry in the same edge: set wins, PEND = 1.
  - CTRL write of EN = 1 and one-shot expiry in the same edge: the bus write wins, EN = 1.
  - Reading STATUS in the expiry cycle returns the pre-edge value.
- IRQ is combinational from registers only (PEND & IRQ_EN), never from bus inputs. It deasserts the cycle after the W1C commit.
- LOAD = 0 in auto-reload mode: expiry on every tick.

Decomposition:
- Package apb_timer_pkg:
  - Register offset localparams: CTRL_OFF = 2'd0, LOAD_OFF = 2'd1, COUNT_OFF = 2'd2, STATUS_OFF = 2'd3.
  - CTRL bit-position constants.
  - Packed struct typedef ctrl_t {prescale, irq_en, auto_reload, en}.
- Sub-module apb_timer_core:
  - Contains the prescaler, counter, and expiry logic.
  - Inputs: load strobe/value, ctrl fields, pend-clear.
  - Outputs: count, expire pulse.
- The top level holds the APB decode, the registers, and the PRDATA register.

Test Plan:
- Reset mid-run: EN = 1 with COUNT = 5, assert HRESETn low for 2 cycles -> all reads return 0x0 and IRQ = 0.
- Register R/W: write CTRL = 0x0000_0306, read it back -> PRDATA = 0x0000_0306, valid in the access phase. Read COUNT after writing 0xDEAD to 0x8 -> value is unchanged.
- One-shot: LOAD = 3, CTRL = 0x5 (EN, IRQ_EN, PRESCALE = 0) -> PEND and IRQ rise 4 cycles after the CTRL commit. Then COUNT = 0 and CTRL reads 0x4.
- Auto-reload with prescale: LOAD = 2, CTRL = 0x0000_0103 (PRESCALE = 1) -> expiries every 6 cycles. Over 60 cycles, count 10 expiries via W1C clears.
- W1C race: arrange a STATUS write of 0x1 on the same edge as an expiry -> PEND stays 1 and IRQ stays high. A W1C one cycle later -> IRQ goes low the next cycle.
- LOAD during count: write LOAD = 0x10 while COUNT = 7 and ticking -> COUNT reads 0x10 after the commit edge, with no decrement that cycle.

Source files
------------

// File: rtl/apb_timer_pkg.sv
// Shared register offsets, CTRL bit positions and the CTRL register layout
// for the APB timer slave.
package apb_timer_pkg;

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] LOAD_OFF   = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;
    localparam logic [1:0] STATUS_OFF = 2'd3;

    localparam int EN_BIT          = 0;
    localparam int AUTO_RELOAD_BIT = 1;
    localparam int IRQ_EN_BIT      = 2;
    localparam int PRESCALE_LSB    = 8;
    localparam int PEND_BIT        = 0;

    typedef struct packed {
        logic [7:0] prescale;
        logic       irq_en;
        logic       auto_reload;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/apb_timer_core.sv
// Prescaler, down-counter with expiry detect, LOAD register and the
// sticky pending flag of the APB timer.
module apb_timer_core #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 en,
    input  logic                 auto_reload,
    input  logic [7:0]           prescale,
    input  logic                 ctrl_wr,
    input  logic                 load_wr,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 pend_clr,
    output logic [CNT_WIDTH-1:0] load,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 expire,
    output logic                 pend
);

    logic [7:0] psc_cnt;
    logic       tick;

    assign tick   = en && (psc_cnt == prescale);
    assign expire = tick && (count == '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            psc_cnt <= 8'd0;
        end else if (ctrl_wr || !en || tick) begin
            psc_cnt <= 8'd0;
        end else begin
            psc_cnt <= psc_cnt + 8'd1;
        end
    end

    // A LOAD write takes priority over any decrement or reload on the same edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            load  <= '0;
            count <= '0;
        end else if (load_wr) begin
            load  <= load_val;
            count <= load_val;
        end else if (tick) begin
            if (count != '0) begin
                count <= count - CNT_WIDTH'(1);
            end else if (auto_reload) begin
                count <= load;
            end
        end
    end

    // Expiry beats a simultaneous write-1-to-clear.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend <= 1'b0;
        end else if (expire) begin
            pend <= 1'b1;
        end else if (pend_clr) begin
            pend <= 1'b0;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB slave: register decode, CTRL register, registered
// PRDATA and the level interrupt around the timer core.
module apb_timer_slave
    import apb_timer_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  IRQ
);

    ctrl_t                 ctrl;
    logic [1:0]            reg_sel;
    logic                  wr_commit;
    logic                  rd_setup;
    logic                  ctrl_wr;
    logic                  load_wr;
    logic                  pend_clr;
    logic [CNT_WIDTH-1:0]  load;
    logic [CNT_WIDTH-1:0]  count;
    logic                  expire;
    logic                  pend;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  unused_bits;

    assign reg_sel   = PADDR[3:2];
    assign wr_commit = PSEL && PENABLE && PWRITE;
    assign rd_setup  = PSEL && !PENABLE && !PWRITE;
    assign ctrl_wr   = wr_commit && (reg_sel == CTRL_OFF);
    assign load_wr   = wr_commit && (reg_sel == LOAD_OFF);
    assign pend_clr  = wr_commit && (reg_sel == STATUS_OFF) && PWDATA[PEND_BIT];
    assign unused_bits = ^{PADDR, PWDATA};

    apb_timer_core #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_core (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .en          (ctrl.en),
        .auto_reload (ctrl.auto_reload),
        .prescale    (ctrl.prescale),
        .ctrl_wr     (ctrl_wr),
        .load_wr     (load_wr),
        .load_val    (PWDATA[CNT_WIDTH-1:0]),
        .pend_clr    (pend_clr),
        .load        (load),
        .count       (count),
        .expire      (expire),
        .pend        (pend)
    );

    // One-shot stop clears EN unless the bus writes CTRL on the same edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl <= '0;
        end else if (ctrl_wr) begin
            ctrl.en          <= PWDATA[EN_BIT];
            ctrl.auto_reload <= PWDATA[AUTO_RELOAD_BIT];
            ctrl.irq_en      <= PWDATA[IRQ_EN_BIT];
            ctrl.prescale    <= 8'(PWDATA[PRESCALE_LSB +: PRESC_WIDTH]);
        end else if (expire && !ctrl.auto_reload) begin
            ctrl.en <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            CTRL_OFF: begin
                rdata[EN_BIT]              = ctrl.en;
                rdata[AUTO_RELOAD_BIT]     = ctrl.auto_reload;
                rdata[IRQ_EN_BIT]          = ctrl.irq_en;
                rdata[PRESCALE_LSB +: 8]   = ctrl.prescale;
            end
            LOAD_OFF:   rdata[CNT_WIDTH-1:0] = load;
            COUNT_OFF:  rdata[CNT_WIDTH-1:0] = count;
            STATUS_OFF: rdata[PEND_BIT]      = pend;
            default:    rdata = '0;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PRDATA <= '0;
        end else if (rd_setup) begin
            PRDATA <= rdata;
        end
    end

    assign IRQ = pend && ctrl.irq_en;

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed and randomized APB traffic against the timer slave, checked
// against a register-level behavioural model of the timer.
module tb_apb_timer_slave;
    import apb_timer_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [31:0] PADDR = 32'h0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        IRQ;

    int checks = 0;
    int failures = 0;

    apb_timer_slave dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .IRQ     (IRQ)
    );

    always #5 HCLK = ~HCLK;

    // Reference model: the programmer-visible registers plus the divider phase.
    logic        m_en, m_ar, m_ie, m_pend;
    logic [7:0]  m_psc, m_div;
    logic [31:0] m_load, m_count, m_prdata;
    logic        m_wr, m_rd, m_tick, m_exp;
    logic [1:0]  m_sel;

    assign m_wr   = PSEL && PENABLE && PWRITE;
    assign m_rd   = PSEL && !PENABLE && !PWRITE;
    assign m_sel  = PADDR[3:2];
    assign m_tick = m_en && (m_div == m_psc);
    assign m_exp  = m_tick && (m_count == 32'h0);

    function automatic logic [31:0] mreg(input logic [1:0] s);
        case (s)
            CTRL_OFF:  return {16'h0, m_psc, 5'h0, m_ie, m_ar, m_en};
            LOAD_OFF:  return m_load;
            COUNT_OFF: return m_count;
            default:   return {31'h0, m_pend};
        endcase
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_en <= 0; m_ar <= 0; m_ie <= 0; m_pend <= 0;
            m_psc <= 0; m_div <= 0; m_load <= 0; m_count <= 0; m_prdata <= 0;
        end else begin
            m_div <= ((m_wr && m_sel == CTRL_OFF) || !m_en || m_tick) ? 8'd0 : m_div + 8'd1;
            if (m_wr && m_sel == LOAD_OFF) begin
                m_load  <= PWDATA;
                m_count <= PWDATA;
            end else if (m_tick) begin
                m_count <= (m_count != 0) ? m_count - 1 : (m_ar ? m_load : 32'h0);
            end
            if (m_exp) m_pend <= 1'b1;
            else if (m_wr && m_sel == STATUS_OFF && PWDATA[0]) m_pend <= 1'b0;
            if (m_wr && m_sel == CTRL_OFF) begin
                m_en <= PWDATA[0]; m_ar <= PWDATA[1]; m_ie <= PWDATA[2]; m_psc <= PWDATA[15:8];
            end else if (m_exp && !m_ar) begin
                m_en <= 1'b0;
            end
            if (m_rd) m_prdata <= mreg(m_sel);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input logic [1:0] off);
        PADDR = $urandom();
        PADDR[3:2] = off;
    endtask

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic apb_wr(input logic [1:0] off, input logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 1; set_addr(off); PWDATA = d;
        @(posedge HCLK); #1 PENABLE = 1;
        @(posedge HCLK); #1 PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = $urandom();
    endtask

    task automatic apb_rd(input logic [1:0] off, output logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 0; set_addr(off);
        @(posedge HCLK); #1 PENABLE = 1; d = PRDATA;
        @(posedge HCLK); #1 PSEL = 0; PENABLE = 0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
        logic [31:0] d;
        apb_rd(off, d);
        chk(tag, d, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge HCLK); #1;
        end
    endtask

    initial begin
        logic [31:0] d;
        int el, n;

        repeat (2) @(posedge HCLK);
        #1 HRESETn = 1;
        chk("reset_irq", 32'(IRQ), 32'h0);
        chk("reset_prdata", PRDATA, 32'h0);
        rd_chk("reset_ctrl", CTRL_OFF, 32'h0);
        rd_chk("reset_load", LOAD_OFF, 32'h0);

        // Reset while running, landing in the access phase of a LOAD write.
        apb_wr(LOAD_OFF, 32'd5);
        apb_wr(CTRL_OFF, 32'h1);
        idle(2);
        PSEL = 1; PWRITE = 1; set_addr(LOAD_OFF); PWDATA = 32'h99;
        @(posedge HCLK); #1 PENABLE = 1; HRESETn = 0;
        @(posedge HCLK); @(posedge HCLK);
        #1 PSEL = 0; PENABLE = 0; PWRITE = 0; HRESETn = 1;
        chk("midrst_irq", 32'(IRQ), 32'h0);
        rd_chk("midrst_ctrl", CTRL_OFF, 32'h0);
        rd_chk("midrst_load", LOAD_OFF, 32'h0);
        rd_chk("midrst_count", COUNT_OFF, 32'h0);
        rd_chk("midrst_status", STATUS_OFF, 32'h0);

        // Register read-back and read-only COUNT.
        apb_wr(CTRL_OFF, 32'h0000_0306);
        rd_chk("ctrl_readback", CTRL_OFF, 32'h0000_0306);
        apb_wr(LOAD_OFF, 32'h55);
        apb_wr(COUNT_OFF, 32'hDEAD);
        rd_chk("count_ro", COUNT_OFF, 32'h55);

        // One-shot: IRQ rises 4 cycles after the CTRL commit, then EN drops.
        apb_wr(LOAD_OFF, 32'd3);
        apb_wr(CTRL_OFF, 32'h5);
        for (int k = 1; k <= 4; k++) begin
            @(posedge HCLK); #1;
            chk($sformatf("oneshot_irq_c%0d", k), 32'(IRQ), (k == 4) ? 32'h1 : 32'h0);
        end
        rd_chk("oneshot_count", COUNT_OFF, 32'h0);
        rd_chk("oneshot_ctrl", CTRL_OFF, 32'h4);
        rd_chk("oneshot_status", STATUS_OFF, 32'h1);
        apb_wr(STATUS_OFF, 32'h1);
        chk("oneshot_w1c_irq", 32'(IRQ), 32'h0);

        // Auto-reload, PRESCALE = 1, LOAD = 2: one expiry every 6 cycles.
        apb_wr(LOAD_OFF, 32'd2);
        apb_wr(CTRL_OFF, 32'h0000_0103);
        el = 0; n = 0;
        while (el < 60) begin
            apb_rd(STATUS_OFF, d); el += 2;
            if (d[0]) begin
                apb_wr(STATUS_OFF, 32'h1); el += 2; n++;
            end
        end
        apb_wr(CTRL_OFF, 32'h0);
        apb_rd(STATUS_OFF, d);
        if (d[0]) begin
            apb_wr(STATUS_OFF, 32'h1); n++;
        end
        chk("autoreload_expiries", 32'(n), 32'd10);

        // W1C committed on the expiry edge: set wins.
        apb_wr(LOAD_OFF, 32'd3);
        apb_wr(CTRL_OFF, 32'h7);
        idle(2);
        apb_wr(STATUS_OFF, 32'h1);
        chk("w1c_race_irq", 32'(IRQ), 32'h1);
        apb_wr(STATUS_OFF, 32'h1);
        chk("w1c_after_irq", 32'(IRQ), 32'h0);
        apb_wr(CTRL_OFF, 32'h0);
        apb_wr(STATUS_OFF, 32'h1);

        // LOAD write while counting overrides that cycle's decrement.
        apb_wr(LOAD_OFF, 32'h14);
        apb_wr(CTRL_OFF, 32'h1);
        idle(12);
        apb_wr(LOAD_OFF, 32'h10);
        rd_chk("load_override", COUNT_OFF, 32'h10);
        rd_chk("load_then_count", COUNT_OFF, 32'hE);
        apb_wr(CTRL_OFF, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [1:0]  off;
            logic [31:0] wd;
            off = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: begin
                    wd = $urandom();
                    if (off == LOAD_OFF) wd = $urandom_range(0, 12);
                    if (off == CTRL_OFF) wd[15:8] = 8'($urandom_range(0, 3));
                    apb_wr(off, wd);
                end
                1: begin
                    apb_rd(off, d);
                    chk($sformatf("rand_rd_%0d", i), d, m_prdata);
                end
                default: idle($urandom_range(1, 4));
            endcase
            chk($sformatf("rand_irq_%0d", i), 32'(IRQ), 32'(m_pend && m_ie));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
